// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy counter,
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module fifo_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           dataIn,
    input  logic                       rd,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           dataOut,
    output logic                       rd_valid,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic                       ALMOST_FULL,
    output logic                       ALMOST_EMPTY,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] data_out_q,  data_out_d;
    logic             rd_valid_q,  rd_valid_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic active;
    logic rd_acc;
    logic wr_acc;
    logic full;
    logic empty;

    // Flags decode only registered state, so they never glitch on input changes.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign active = en && !flush;
    assign rd_acc = active && rd && !empty;
    assign wr_acc = active && wr && (!full || rd_acc);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rd_acc) begin
                data_out_d = mem_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + PW'(1);
                rd_valid_d = 1'b1;
            end
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A new error in the same cycle as clr_err must survive the clear.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (active && wr && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (active && rd && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
    end

    assign dataOut      = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (count_q >= CW'(AF_LEVEL));
    assign ALMOST_EMPTY = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed, table-driven bench for fifo_param at its default 32x8 configuration.
module tb_fifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, flush, wr, rd, clr_err;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        rd_valid, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
    logic [3:0]  count;
    logic        overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          en, flush, wr, rd, clr;
        logic [31:0] din;
        int          cnt;
        logic [31:0] dout;
        bit          rv, ovf, udf;
    } vec_t;

    vec_t vecs[$];

    fifo_param dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .wr(wr), .dataIn(dataIn),
        .rd(rd), .clr_err(clr_err), .dataOut(dataOut), .rd_valid(rd_valid),
        .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Expected flags follow directly from the expected occupancy (DEPTH 8, AF 6, AE 2).
    function automatic logic [42:0] expect_pack(int c, logic [31:0] d, bit rv, bit ov, bit un);
        logic full_e, empty_e, af_e, ae_e;
        full_e  = (c == 8);
        empty_e = (c == 0);
        af_e    = (c >= 6);
        ae_e    = (c <= 2);
        return {4'(c), full_e, empty_e, af_e, ae_e, d, rv, ov, un};
    endfunction

    function automatic logic [42:0] actual_pack();
        return {count, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, dataOut, rd_valid, overflow, underflow};
    endfunction

    task automatic check(input string name, input logic [42:0] exp_v);
        logic [42:0] act_v;
        act_v = actual_pack();
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d F=%b E=%b AF=%b AE=%b dout=%h rv=%b ovf=%b udf=%b, want cnt=%0d F=%b E=%b AF=%b AE=%b dout=%h rv=%b ovf=%b udf=%b",
                     name, act_v[42:39], act_v[38], act_v[37], act_v[36], act_v[35], act_v[34:3],
                     act_v[2], act_v[1], act_v[0], exp_v[42:39], exp_v[38], exp_v[37], exp_v[36],
                     exp_v[35], exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic add(input bit e, input bit f, input bit w, input bit r, input bit c,
                       input logic [31:0] d, input int cnt, input logic [31:0] dout,
                       input bit rv, input bit ov, input bit un);
        vec_t t;
        t.en = e; t.flush = f; t.wr = w; t.rd = r; t.clr = c; t.din = d;
        t.cnt = cnt; t.dout = dout; t.rv = rv; t.ovf = ov; t.udf = un;
        vecs.push_back(t);
    endtask

    // Called just after a rising edge: drive, take one edge, check.
    task automatic run(input string name, input vec_t t);
        en = t.en; flush = t.flush; wr = t.wr; rd = t.rd; clr_err = t.clr; dataIn = t.din;
        @(posedge clk);
        #1;
        check(name, expect_pack(t.cnt, t.dout, t.rv, t.ovf, t.udf));
    endtask

    initial begin
        vec_t h;

        // Fill with 0x11..0x88, then a refused 9th write
        for (int i = 1; i <= 8; i++) add(1, 0, 1, 0, 0, 32'h11 * i, i, 32'h0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 32'h99, 8, 32'h0, 0, 1, 0);
        // Drain in order, then a refused read
        for (int i = 1; i <= 8; i++) add(1, 0, 0, 1, 0, 32'h0, 8 - i, 32'h11 * i, 1, 1, 0);
        add(1, 0, 0, 1, 0, 32'h0, 0, 32'h88, 0, 1, 1);
        add(1, 0, 0, 0, 1, 32'h0, 0, 32'h88, 0, 0, 0);
        // Simultaneous read+write at FULL, with wrap-around
        for (int i = 1; i <= 8; i++) add(1, 0, 1, 0, 0, i, i, 32'h88, 0, 0, 0);
        add(1, 0, 1, 1, 0, 32'hAA, 8, 32'h1, 1, 0, 0);
        for (int i = 2; i <= 8; i++) add(1, 0, 0, 1, 0, 32'h0, 9 - i, i, 1, 0, 0);
        add(1, 0, 0, 1, 0, 32'h0, 0, 32'hAA, 1, 0, 0);
        // Simultaneous read+write at EMPTY: no fall-through
        add(1, 0, 1, 1, 0, 32'h5, 1, 32'hAA, 0, 0, 1);
        add(1, 0, 0, 1, 0, 32'h0, 0, 32'h5, 1, 0, 1);
        add(1, 0, 0, 0, 1, 32'h0, 0, 32'h5, 0, 0, 0);
        // en=0 hold at count 5, then flush discarding rd/wr
        for (int i = 1; i <= 5; i++) add(1, 0, 1, 0, 0, 32'h30 + i, i, 32'h5, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 32'hEE, 5, 32'h5, 0, 0, 0);
        add(1, 1, 1, 1, 0, 32'hEE, 0, 32'h5, 0, 0, 0);
        // clr_err coinciding with a new underflow: set wins; clr_err acts with en=0
        add(1, 0, 0, 1, 1, 32'h0, 0, 32'h5, 0, 0, 1);
        add(0, 0, 0, 0, 1, 32'h0, 0, 32'h5, 0, 0, 0);
        // Flush with en=0, then pointers restart at entry 0
        add(1, 0, 1, 0, 0, 32'h41, 1, 32'h5, 0, 0, 0);
        add(1, 0, 1, 0, 0, 32'h42, 2, 32'h5, 0, 0, 0);
        add(0, 1, 0, 0, 0, 32'h0, 0, 32'h5, 0, 0, 0);
        add(1, 0, 1, 0, 0, 32'h43, 1, 32'h5, 0, 0, 0);
        add(1, 0, 0, 1, 0, 32'h0, 0, 32'h43, 1, 0, 0);

        rst = 1'b0; en = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; dataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", expect_pack(0, 32'h0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);

        // Asynchronous reset mid-cycle with 4 entries held
        for (int i = 1; i <= 4; i++) begin
            h.en = 1; h.flush = 0; h.wr = 1; h.rd = 0; h.clr = 0; h.din = 32'h60 + i;
            h.cnt = i; h.dout = 32'h43; h.rv = 0; h.ovf = 0; h.udf = 0;
            run($sformatf("prefill%0d", i), h);
        end
        wr = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", expect_pack(0, 32'h0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        h.en = 1; h.flush = 0; h.wr = 1; h.rd = 0; h.clr = 0; h.din = 32'h7;
        h.cnt = 1; h.dout = 32'h0; h.rv = 0; h.ovf = 0; h.udf = 0;
        run("post_reset_wr", h);
        h.wr = 0; h.rd = 1; h.din = 32'h0; h.cnt = 0; h.dout = 32'h7; h.rv = 1;
        run("post_reset_rd", h);
        h.rd = 0; h.rv = 0;
        run("rd_valid_drop", h);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
